// File: rtl/eceg_selftest_ctrl_pkg.sv
// Shared definitions for the ECEG self-test controller: data width, state
// encoding and the maximal-length Galois LFSR tap masks.
package eceg_selftest_ctrl_pkg;

  localparam int DATAWIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Right-shifting Galois tap masks: bit (k-1) is set for polynomial tap k.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      4:       return 64'h0000_000C;
      5:       return 64'h0000_0014;
      6:       return 64'h0000_0030;
      7:       return 64'h0000_0060;
      8:       return 64'h0000_00B8;
      12:      return 64'h0000_0829;
      16:      return 64'h0000_B400;
      24:      return 64'h00E1_0000;
      32:      return 64'h8020_0003;
      default: return 64'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/eceg_selftest_ctrl_lfsr.sv
// Galois LFSR producing the plaintext stream. A zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module eceg_lfsr
  import eceg_selftest_ctrl_pkg::*;
#(
  parameter int              DW   = DATAWIDTH,
  parameter logic [DW-1:0]   TAPS = DW'(lfsr_taps(DW))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          step,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_q, q_d, seed_safe;

  // Load has priority over step; shift right and fold taps in when bit 0 falls out.
  always_comb begin
    seed_safe = (seed == '0) ? DW'(1) : seed;
    q_d       = q_q;
    if (load) begin
      q_d = seed_safe;
    end else if (step) begin
      q_d = q_q[0] ? ((q_q >> 1) ^ TAPS) : (q_q >> 1);
    end
  end

  // State register; reset returns to the (guarded) seed.
  always_ff @(posedge clk) begin
    if (rst) q_q <= seed_safe;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/eceg_selftest_ctrl.sv
// Self-test stimulus/checker wrapped around the ECEG datapath: drives LFSR
// plaintexts, waits a settle window, compares the decrypted word and the
// check flag, and accumulates run statistics.
//
// state   | meaning
// IDLE    | waiting for start, outputs hold last-run results
// LOAD    | present next LFSR value on msg_out, arm settle counter
// SETTLE  | hold msg_out while the datapath settles
// COMPARE | sample dec_in/check_in and update statistics
// FIN     | one-cycle done pulse, then back to IDLE
module eceg_selftest_ctrl
  import eceg_selftest_ctrl_pkg::*;
#(
  parameter int            DW            = DATAWIDTH,
  parameter int            NUM_VECTORS   = 256,
  parameter int            SETTLE_CYCLES = 4,
  parameter logic [DW-1:0] SEED          = DW'(1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [DW-1:0] msg_out,
  input  logic [DW-1:0] dec_in,
  input  logic          check_in,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   vec_count,
  output logic [15:0]   err_count,
  output logic [DW-1:0] first_fail
);

  localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
  localparam logic [15:0] VEC_LAST    = 16'(NUM_VECTORS);

  state_e          state_q, state_d;
  logic [DW-1:0]   msg_q, msg_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [15:0]     vec_q, vec_d;
  logic [15:0]     err_q, err_d;
  logic [DW-1:0]   ff_q, ff_d;
  logic            lfsr_load, lfsr_step;
  logic [DW-1:0]   lfsr_q;
  logic            fail;

  eceg_lfsr #(.DW(DW)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    vec_d     = vec_q;
    err_d     = err_q;
    ff_d      = ff_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    fail      = (dec_in != msg_q) | ~check_in;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          vec_d     = '0;
          err_d     = '0;
          ff_d      = '0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        msg_d     = lfsr_q;
        lfsr_step = 1'b1;
        cnt_d     = SETTLE_INIT;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_COMPARE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_COMPARE: begin
        vec_d = vec_q + 16'd1;
        if (fail) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == 16'd0)    ff_d  = msg_q;
        end
        if (vec_d == VEC_LAST) begin
          // pass is settled together with done so it is valid during the pulse
          done_d  = 1'b1;
          pass_d  = (err_d == 16'd0);
          state_d = ST_FIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All controller state and registered outputs; reset aborts any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign msg_out    = msg_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign vec_count  = vec_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_eceg_selftest_ctrl.sv
// Self-checking bench for eceg_selftest_ctrl: three instances with different
// parameter sets, randomized error injection checked against a plaintext model.
module tb_eceg_selftest_ctrl;

  localparam int          NA     = 8;
  localparam int          SA     = 4;
  localparam logic [15:0] SEED_A = 16'hACE1;
  localparam int          NB     = 300;
  localparam int          SB     = 2;
  localparam logic [15:0] SEED_B = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // instance A: short runs with injected faults
  logic        rst_a = 1'b1, start_a = 1'b0, chk_a = 1'b1;
  logic [15:0] dec_a = '0, msg_a, vec_a, err_a, ff_a;
  logic        busy_a, done_a, pass_a;
  // instance B: long run with check flag held low
  logic        rst_b = 1'b1, start_b = 1'b0, chk_b = 1'b0;
  logic [15:0] dec_b, msg_b, vec_b, err_b, ff_b;
  logic        busy_b, done_b, pass_b;
  // instance C: zero seed, single vector, loopback
  logic        rst_c = 1'b1, start_c = 1'b0;
  logic [15:0] dec_c, msg_c, vec_c, err_c, ff_c;
  logic        busy_c, done_c, pass_c;

  assign dec_b = msg_b;
  assign dec_c = msg_c;

  eceg_selftest_ctrl #(.DW(16), .NUM_VECTORS(NA), .SETTLE_CYCLES(SA), .SEED(SEED_A)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .msg_out(msg_a), .dec_in(dec_a),
    .check_in(chk_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .vec_count(vec_a), .err_count(err_a), .first_fail(ff_a));

  eceg_selftest_ctrl #(.DW(16), .NUM_VECTORS(NB), .SETTLE_CYCLES(SB), .SEED(SEED_B)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .msg_out(msg_b), .dec_in(dec_b),
    .check_in(chk_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .vec_count(vec_b), .err_count(err_b), .first_fail(ff_b));

  eceg_selftest_ctrl #(.DW(16), .NUM_VECTORS(1), .SETTLE_CYCLES(4), .SEED(16'h0000)) u_dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .msg_out(msg_c), .dec_in(dec_c),
    .check_in(1'b1), .busy(busy_c), .done(done_c), .pass(pass_c),
    .vec_count(vec_c), .err_count(err_c), .first_fail(ff_c));

  // Plaintext sequence x^16+x^14+x^13+x^11+1 expressed as polynomial multiplication by x^-1.
  function automatic logic [15:0] model_next(input logic [15:0] x);
    if ((x % 2) == 1) return (x / 2) ^ 16'hB400;
    return x / 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(); tick();
    n_vec++;
    if ({msg_a, busy_a, done_a, pass_a, vec_a, err_a, ff_a} !== '0) begin
      n_err++;
      $display("FAIL reset_a: got msg=%h busy=%b done=%b pass=%b vec=%0d err=%0d ff=%h, want all 0",
               msg_a, busy_a, done_a, pass_a, vec_a, err_a, ff_a);
    end
    n_vec++;
    if ({msg_b, busy_b, done_b, pass_b, vec_b, err_b, ff_b} !== '0) begin
      n_err++;
      $display("FAIL reset_b: outputs not all 0 (msg=%h vec=%0d err=%0d)", msg_b, vec_b, err_b);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();
  endtask

  // One run on instance A. corrupt[k] flips dec_in bit 0 on vector k, bad_chk[k]
  // drops check_in on vector k, poke>0 pulses start at that run cycle.
  task automatic run_a(input logic [NA-1:0] corrupt, input logic [NA-1:0] bad_chk,
                       input int poke, input string name);
    logic [15:0] msgs [NA];
    logic [15:0] exp_ff;
    int exp_err, cyc, k;
    bit got_done;
    msgs[0] = SEED_A;
    for (int i = 1; i < NA; i++) msgs[i] = model_next(msgs[i-1]);
    exp_err = 0; exp_ff = '0;
    for (int i = 0; i < NA; i++) begin
      if (corrupt[i] || bad_chk[i]) begin
        if (exp_err == 0) exp_ff = msgs[i];
        exp_err++;
      end
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1; got_done = 0;
    while (cyc <= 70 && !got_done) begin
      k = (cyc - 1) / (SA + 2);
      if (k < NA) begin
        dec_a = msgs[k] ^ (corrupt[k] ? 16'h0001 : 16'h0000);
        chk_a = ~bad_chk[k];
        if ((cyc - 1) % (SA + 2) == 2) begin
          n_vec++;
          if (msg_a !== msgs[k]) begin
            n_err++;
            $display("FAIL %s msg_out[%0d]: got %h want %h", name, k, msg_a, msgs[k]);
          end
        end
      end
      start_a = (cyc == poke);
      if (cyc == 1) begin
        n_vec++;
        if (busy_a !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_start: got %b want 1", name, busy_a);
        end
      end
      if (done_a === 1'b1) got_done = 1;
      else begin tick(); cyc++; end
    end
    start_a = 1'b0;
    n_vec++;
    if (!got_done || cyc != NA * (SA + 2) + 1) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d (seen=%0d) want %0d", name, cyc, got_done, NA * (SA + 2) + 1);
    end
    n_vec++;
    if (vec_a !== 16'(NA) || err_a !== 16'(exp_err) || ff_a !== exp_ff || pass_a !== (exp_err == 0)
        || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL %s stats: got vec=%0d err=%0d ff=%h pass=%b busy=%b want vec=%0d err=%0d ff=%h pass=%b busy=1",
               name, vec_a, err_a, ff_a, pass_a, busy_a, NA, exp_err, exp_ff, exp_err == 0);
    end
    tick();
    n_vec++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || pass_a !== (exp_err == 0) || msg_a !== msgs[NA-1]) begin
      n_err++;
      $display("FAIL %s idle_after: got done=%b busy=%b pass=%b msg=%h want 0 0 %b %h",
               name, done_a, busy_a, pass_a, msg_a, exp_err == 0, msgs[NA-1]);
    end
    tick();
  endtask

  task automatic test_loopback();
    run_a('0, '0, 0, "loopback");
  endtask

  task automatic test_third_vector_error();
    run_a(8'b0000_0100, '0, 0, "third_err");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_a(NA'($urandom), NA'($urandom & $urandom & $urandom), 0, $sformatf("rand%0d", r));
  endtask

  task automatic test_check_low_long();
    int cyc;
    bit got_done;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1; got_done = 0;
    while (cyc <= 1400 && !got_done) begin
      if (done_b === 1'b1) got_done = 1;
      else begin tick(); cyc++; end
    end
    n_vec++;
    if (!got_done || cyc != NB * (SB + 2) + 1) begin
      n_err++;
      $display("FAIL check_low done_cycle: got %0d want %0d", cyc, NB * (SB + 2) + 1);
    end
    n_vec++;
    if (vec_b !== 16'(NB) || err_b !== 16'(NB) || ff_b !== SEED_B || pass_b !== 1'b0) begin
      n_err++;
      $display("FAIL check_low stats: got vec=%0d err=%0d ff=%h pass=%b want %0d %0d %h 0",
               vec_b, err_b, ff_b, pass_b, NB, NB, SEED_B);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c < 5; c++) begin
      dec_a = msg_a; chk_a = 1'b1;
      tick();
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_vec++;
    if ({msg_a, busy_a, done_a, pass_a, vec_a, err_a, ff_a} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got msg=%h busy=%b done=%b pass=%b vec=%0d err=%0d, want all 0",
               msg_a, busy_a, done_a, pass_a, vec_a, err_a);
    end
    saw_done = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_a === 1'b1 || busy_a === 1'b1) saw_done = 1;
      tick();
    end
    n_vec++;
    if (saw_done) begin
      n_err++;
      $display("FAIL mid_reset activity: got done/busy after abort, want none");
    end
    run_a('0, '0, 0, "after_reset");
  endtask

  task automatic test_start_ignored();
    rst_a = 1'b1; start_a = 1'b1;
    tick();
    rst_a = 1'b0; start_a = 1'b0;
    tick(); tick();
    n_vec++;
    if (busy_a !== 1'b0 || msg_a !== 16'h0000) begin
      n_err++;
      $display("FAIL start_with_rst: got busy=%b msg=%h want 0 0000", busy_a, msg_a);
    end
    run_a(8'b0100_0000, '0, 10, "start_busy");
  endtask

  task automatic test_zero_seed_single();
    int cyc;
    bit got_done;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    cyc = 1; got_done = 0;
    while (cyc <= 20 && !got_done) begin
      if (cyc == 3) begin
        n_vec++;
        if (msg_c !== 16'h0001) begin
          n_err++;
          $display("FAIL zero_seed msg: got %h want 0001", msg_c);
        end
      end
      if (done_c === 1'b1) got_done = 1;
      else begin tick(); cyc++; end
    end
    n_vec++;
    if (!got_done || cyc != 7 || pass_c !== 1'b1 || vec_c !== 16'd1 || err_c !== 16'd0) begin
      n_err++;
      $display("FAIL zero_seed run: got cyc=%0d pass=%b vec=%0d err=%0d want 7 1 1 0",
               cyc, pass_c, vec_c, err_c);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_third_vector_error();
    test_check_low_long();
    test_reset_mid_run();
    test_start_ignored();
    test_zero_seed_single();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
